// File: rtl/gf180mcu_fd_sc_mcu9t5v0__orn_pkg.sv
// Shared constants and elaboration-time helpers for the fan-in-4 OR reduction cell.
package gf180mcu_fd_sc_mcu9t5v0__orn_pkg;

  localparam int OR_FANIN  = 4;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;
  localparam int MAX_LEV   = 8;

  // Signal count left after k fan-in-4 levels applied to n inputs.
  function automatic int level_width(input int n, input int k);
    int w;
    w = n;
    for (int i = 0; i < MAX_LEV; i++) begin
      if (i < k) w = (w + OR_FANIN - 1) / OR_FANIN;
    end
    return w;
  endfunction

  // Number of tree levels needed to reduce n signals to one, never below 1.
  function automatic int clog4(input int n);
    int lev;
    lev = 0;
    for (int i = 0; i < MAX_LEV; i++) begin
      if (level_width(n, i) > 1) lev = i + 1;
    end
    return (lev < 1) ? 1 : lev;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__orn_level.sv
// One fan-in-4 OR level: IN_W inputs reduced to ceil(IN_W/4) outputs,
// optionally registered with an async active-low reset.
module gf180mcu_fd_sc_mcu9t5v0__orn_level
  import gf180mcu_fd_sc_mcu9t5v0__orn_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int REG  = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [IN_W-1:0]                          d,
  output logic [(IN_W+OR_FANIN-1)/OR_FANIN-1:0]    y
);

  localparam int OUT_W = (IN_W + OR_FANIN - 1) / OR_FANIN;
  localparam int PAD_W = OUT_W * OR_FANIN;

  logic [PAD_W-1:0] d_pad;
  logic [OUT_W-1:0] or_comb;

  // The partial last group is padded with zeros so it cannot assert spuriously.
  if (PAD_W > IN_W) begin : g_pad
    assign d_pad = {{(PAD_W - IN_W){1'b0}}, d};
  end else begin : g_nopad
    assign d_pad = d;
  end

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_or
    assign or_comb[gi] = |d_pad[gi*OR_FANIN +: OR_FANIN];
  end

  if (REG != 0) begin : g_reg
    logic [OUT_W-1:0] y_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) y_reg <= '0;
      else        y_reg <= or_comb;
    end
    assign y = y_reg;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign y = or_comb;
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__orn_sticky.sv
// N-input OR-reduction cell with per-channel capture register and registered Z.
// Define GF180MCU_FD_SC_MCU9T5V0_ORN_EDGE_EN to capture rising edges instead of levels.
module gf180mcu_fd_sc_mcu9t5v0__orn_sticky
  import gf180mcu_fd_sc_mcu9t5v0__orn_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int PIPE   = 0,
  parameter int STICKY = 0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] MASK,
  input  logic [WIDTH-1:0] CLR,
  output logic [WIDTH-1:0] Q,
  output logic             Z
);

  localparam int NLEV = clog4(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("orn_sticky: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
    $error("orn_sticky: PIPE must be 0 or 1");
  end
  if (STICKY != 0 && STICKY != 1) begin : g_bad_sticky
    $error("orn_sticky: STICKY must be 0 or 1");
  end

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_reg;

`ifdef GF180MCU_FD_SC_MCU9T5V0_ORN_EDGE_EN
  // Previous sample tracks A regardless of MASK so unmasking never fakes an edge.
  logic [WIDTH-1:0] a_prev_reg;
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) a_prev_reg <= '0;
    else     a_prev_reg <= A;
  end
  assign a_eff = A & ~a_prev_reg & ~MASK;
`else
  assign a_eff = A & ~MASK;
`endif

  // Set has priority over clear; in level mode nothing is held.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    assign hold[gi]   = (STICKY != 0) & q_reg[gi] & ~CLR[gi];
    assign q_next[gi] = a_eff[gi] | hold[gi];
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) q_reg <= '0;
    else     q_reg <= q_next;
  end

  assign Q = q_reg;

  for (genvar gi = 0; gi < NLEV; gi++) begin : g_lev
    localparam int IW = level_width(WIDTH, gi);
    localparam int OW = level_width(WIDTH, gi + 1);
    logic [IW-1:0] lev_d;
    logic [OW-1:0] lev_y;

    if (gi == 0) begin : g_first
      assign lev_d = q_reg;
    end else begin : g_chain
      assign lev_d = g_lev[gi-1].lev_y;
    end

    gf180mcu_fd_sc_mcu9t5v0__orn_level #(
      .IN_W (IW),
      .REG  (PIPE)
    ) u_level (
      .clk   (CLK),
      .rst_n (RN),
      .d     (lev_d),
      .y     (lev_y)
    );
  end

  logic tree_root;
  assign tree_root = g_lev[NLEV-1].lev_y[0];

  // Z is always a flop output: the last tree level when pipelined, else a dedicated register.
  if (PIPE != 0) begin : g_z_pipe
    assign Z = tree_root;
  end else begin : g_z_reg
    logic z_reg;
    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) z_reg <= 1'b0;
      else     z_reg <= tree_root;
    end
    assign Z = z_reg;
  end

`ifndef FUNCTIONAL
  specify
    (CLK => Z) = (1, 1);
    (CLK *> Q) = (1, 1);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__orn_sticky.sv
// Randomised and directed bench for the OR-reduction cell across four configurations.
module tb_gf180mcu_fd_sc_mcu9t5v0__orn_sticky;

  localparam int NI = 4;
  // Instance widths, sticky modes and A->Z latency minus one (history index).
  localparam int MW [NI] = '{8, 64, 13, 4};
  localparam bit MS [NI] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam int ZI [NI] = '{1, 3, 2, 1};

  logic        clk = 1'b0;
  logic        rn;
  logic [63:0] a, mask, clr;
  logic        chk_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic [7:0]  q_a;  logic z_a;
  logic [63:0] q_b;  logic z_b;
  logic [12:0] q_c;  logic z_c;
  logic [3:0]  q_d4; logic z_d4;

  logic [63:0] q_m  [NI];
  logic [7:0]  zh_m [NI];
  logic [63:0] prev_m;
  logic [63:0] q_dut [NI];
  logic        z_dut [NI];

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__orn_sticky #(.WIDTH(8), .PIPE(0), .STICKY(1)) u_a (
    .CLK(clk), .RN(rn), .A(a[7:0]), .MASK(mask[7:0]), .CLR(clr[7:0]), .Q(q_a), .Z(z_a));
  gf180mcu_fd_sc_mcu9t5v0__orn_sticky #(.WIDTH(64), .PIPE(1), .STICKY(0)) u_b (
    .CLK(clk), .RN(rn), .A(a), .MASK(mask), .CLR(clr), .Q(q_b), .Z(z_b));
  gf180mcu_fd_sc_mcu9t5v0__orn_sticky #(.WIDTH(13), .PIPE(1), .STICKY(1)) u_c (
    .CLK(clk), .RN(rn), .A(a[12:0]), .MASK(mask[12:0]), .CLR(clr[12:0]), .Q(q_c), .Z(z_c));
  gf180mcu_fd_sc_mcu9t5v0__orn_sticky #(.WIDTH(4), .PIPE(0), .STICKY(0)) u_d (
    .CLK(clk), .RN(rn), .A(a[3:0]), .MASK(mask[3:0]), .CLR(clr[3:0]), .Q(q_d4), .Z(z_d4));

  assign q_dut[0] = {56'b0, q_a};
  assign q_dut[1] = q_b;
  assign q_dut[2] = {51'b0, q_c};
  assign q_dut[3] = {60'b0, q_d4};
  assign z_dut[0] = z_a;
  assign z_dut[1] = z_b;
  assign z_dut[2] = z_c;
  assign z_dut[3] = z_d4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      q_m[i]  = '0;
      zh_m[i] = '0;
    end
    prev_m = '0;
  endtask

  // Channel status from the capture rules; Z is the OR of Q seen latency-1 cycles ago.
  task automatic model_step();
    logic [63:0] wm, ev;
    for (int i = 0; i < NI; i++) begin
      wm = (MW[i] == 64) ? '1 : ((64'd1 << MW[i]) - 64'd1);
      ev = a & ~mask & wm;
`ifdef GF180MCU_FD_SC_MCU9T5V0_ORN_EDGE_EN
      ev = ev & ~prev_m;
`endif
      q_m[i]  = MS[i] ? (ev | (q_m[i] & ~clr & wm)) : ev;
      zh_m[i] = {zh_m[i][6:0], |q_m[i]};
    end
    prev_m = a;
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rn) model_step();
      #2;
    end
  endtask

  task automatic drive(input logic [63:0] na, input logic [63:0] nm, input logic [63:0] nc);
    a = na; mask = nm; clr = nc;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("q%0d", i), q_dut[i], q_m[i]);
          check($sformatf("z%0d", i), {63'b0, z_dut[i]}, {63'b0, zh_m[i][ZI[i]]});
        end
      end
    end
  end

  initial begin
    logic [63:0] r;
    rn = 1'b0;
    drive('0, '0, '0);
    model_reset();
    cycle(2);
    chk_en = 1'b1;
    check("reset_q_a", q_dut[0], 64'h0);
    check("reset_z_b", {63'b0, z_b}, 64'h0);
    rn = 1'b1;

    // Mid-stream reset with all inputs high.
    drive('1, '0, '0);
    cycle(3);
    rn = 1'b0;
    model_reset();
    #1;
    check("rst_async_q_a", q_dut[0], 64'h0);
    check("rst_async_z_a", {63'b0, z_a}, 64'h0);
    cycle(1);
    rn = 1'b1;
    cycle(1);
    check("rst_rel_q_a", q_dut[0], 64'hFF);
    check("rst_rel_z_a0", {63'b0, z_a}, 64'h0);
    cycle(1);
    check("rst_rel_z_a1", {63'b0, z_a}, 64'h1);

    // Sticky set/clear race on channel 2 of the 8-bit sticky instance.
    drive('0, '0, '1); cycle(1);
    check("race_clr_all", q_dut[0], 64'h0);
    drive(64'h4, '0, '0); cycle(1);
    drive('0, '0, '0); cycle(1);
    check("race_hold", q_dut[0], 64'h4);
    drive(64'h4, '0, 64'h4); cycle(1);
    check("race_set_wins", q_dut[0], 64'h4);
    drive('0, '0, 64'h4); cycle(1);
    check("race_cleared", q_dut[0], 64'h0);

    // Level mode single pulse on the 4-bit instance.
    drive('0, '0, '0); cycle(4);
    drive(64'h4, '0, '0); cycle(1);
    check("lvl_q1", q_dut[3], 64'h4);
    check("lvl_z1", {63'b0, z_d4}, 64'h0);
    drive('0, '0, '0); cycle(1);
    check("lvl_q2", q_dut[3], 64'h0);
    check("lvl_z2", {63'b0, z_d4}, 64'h1);
    cycle(1);
    check("lvl_z3", {63'b0, z_d4}, 64'h0);

    // Masking: everything masked, then only channel 0 unmasked.
    drive('0, '0, '1); cycle(1);
    drive('1, '1, '0); cycle(4);
    check("mask_all_q_c", q_dut[2], 64'h0);
    check("mask_all_z_c", {63'b0, z_c}, 64'h0);
    check("mask_all_z_b", {63'b0, z_b}, 64'h0);
    drive(~64'h1, ~64'h1, '0); cycle(1);
    check("mask_fffe_q_c", q_dut[2], 64'h0);
    drive(64'h1, ~64'h1, '0); cycle(1);
    check("mask_unm_q_c", q_dut[2], 64'h1);
    drive('0, ~64'h1, '0); cycle(1);
    check("mask_unm_z_c0", {63'b0, z_c}, 64'h0);
    cycle(1);
    check("mask_unm_z_c1", {63'b0, z_c}, 64'h1);

    // 64-wide pipelined tree: latency 4, then back-to-back pulses.
    drive('0, '0, '0); cycle(5);
    check("pipe_idle", {63'b0, z_b}, 64'h0);
    drive(64'h1 << 63, '0, '0); cycle(1);
    check("pipe_q63", q_b, 64'h8000_0000_0000_0000);
    drive('0, '0, '0);
    for (int k = 2; k <= 5; k++) begin
      cycle(1);
      check($sformatf("pipe_z_c%0d", k), {63'b0, z_b}, (k == 4) ? 64'h1 : 64'h0);
    end
    drive(64'h1, '0, '0); cycle(1);
    drive(64'h1 << 40, '0, '0); cycle(1);
    drive('0, '0, '0); cycle(1);
    cycle(1);
    check("b2b_z1", {63'b0, z_b}, 64'h1);
    cycle(1);
    check("b2b_z2", {63'b0, z_b}, 64'h1);
    cycle(1);
    check("b2b_z3", {63'b0, z_b}, 64'h0);

    // Random traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = 64'h1 << $urandom_range(0, 63);
        2: r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: r = {$urandom, $urandom};
      endcase
      drive(r, {$urandom, $urandom} & {$urandom, $urandom},
            {$urandom, $urandom} & {$urandom, $urandom});
      if ($urandom_range(0, 79) == 0) begin
        rn = 1'b0;
        model_reset();
        cycle(1);
        rn = 1'b1;
      end else begin
        cycle(1);
      end
    end

    drive('0, '0, '0);
    cycle(6);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
